exposure_sequencer: RTL and testbench
=====================================

Name: exposure_sequencer

Overview:
Executes one UV exposure run when the front panel fires: writes the LED intensity to the digipot through the I2C controller, pulses the UV enable for the programmed on/off times and repetition count, then writes intensity 0. Sits between the panel state/value registers in top and i2c_controller plus the UV driver pin. All timing is in milliseconds, derived from the 16 MHz clock.

Parameters:
TICK_DIV, 16000, clk cycles per 1 ms tick (sim benches override to 4)
TIME_W, 16, width of on/off time inputs in ms
REP_W, 8, width of repetition count
INT_MAX, 100, intensity clamp value
I2C_ACK_TO, 8, cycles to wait for i2c_ready to fall after a request before the write is treated as done
SOFT_MS, 50, soft-start hold in ms (only with SOFT_START_EN)

Ports:
clk  in  1  system clock (16 MHz)
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse on entry to FIRE; ignored while busy
abort  in  1  level; terminates the run safely
on_time  in  TIME_W  ms per ON phase, sampled on start
off_time  in  TIME_W  ms per OFF phase, sampled on start
repetitions  in  REP_W  number of ON phases, sampled on start
intensity  in  8  digipot code, sampled on start, clamped to INT_MAX
i2c_ready  in  1  from i2c_controller.ready
i2c_enable  out  1  one-cycle request to i2c_controller.enable
i2c_data  out  8  to i2c_controller.data_in; stable from request until the write completes
uv_en  out  1  UV LED driver enable
busy  out  1  high from the cycle after accepted start until DONE exits
done  out  1  one-cycle pulse at end of run (normal or aborted)
rep_count  out  REP_W  completed ON phases in the current/last run

Behaviour:
- Reset values: i2c_enable=0, i2c_data=0, uv_en=0, busy=0, done=0, rep_count=0, state=IDLE. Reset mid-run drops uv_en on the same edge. No zero-intensity write is issued.
- States: IDLE, WR_INT, WAIT_WR, ON, OFF, WR_ZERO, WAIT_ZERO, DONE.
- IDLE: start=1 latches inputs, clears rep_count, sets busy. If repetitions==0, go to DONE with no I2C traffic and uv_en never high. Otherwise go to WR_INT.
- WR_INT / WR_ZERO: wait until i2c_ready=1, then pulse i2c_enable for exactly 1 cycle with i2c_data = clamped intensity (or 0). Go to WAIT_WR / WAIT_ZERO.
- WAIT_*: the write is complete when i2c_ready is seen low and then high again. If ready never falls within I2C_ACK_TO cycles, the write is complete at the timeout. WAIT_WR goes to ON. WAIT_ZERO goes to DONE.
- Millisecond timer: the prescaler and ms counter clear on entry to each timed phase. A phase of N ms lasts exactly N*TICK_DIV cycles.
- ON: uv_en=1 for exactly on_time ms. If on_time==0, the ON phase is zero length and uv_en stays low, but the phase still counts. On exit, rep_count increments (saturates at all-ones). If rep_count equals repetitions, go to WR_ZERO. Else go to OFF.
- OFF: uv_en=0 for off_time ms, then return to ON. No OFF phase follows the final repetition. off_time==0 means direct ON→ON with uv_en continuous.
- DONE: done=1 for one cycle, busy falls the next cycle, return to IDLE.
- abort (any busy state): uv_en=0 on the next edge, then:
  - from ON or OFF, go to WR_ZERO;
  - during WAIT_WR, finish the pending write, then WR_ZERO;
  - in WR_ZERO, WAIT_ZERO or DONE, abort has no extra effect.
  - A simultaneous start and abort in IDLE is ignored.
- start during busy is ignored. Latched values are unaffected by input changes mid-run.
- Intensity > INT_MAX is sent as INT_MAX. Bit 7 of i2c_data is always 0.

Optional Feature:
SOFT_START_EN defined:
- Before the first ON phase only, insert a write of clamped_intensity>>1, then SOFT_MS ms with uv_en=1.
- Then perform the normal full-intensity write; uv_en stays high during that write.
- The soft hold does not count toward on_time or rep_count.
- abort during the soft hold behaves as in ON.
Undefined: no soft-start states, behaviour exactly as above.

Test Plan:
- TICK_DIV=4, on=3, off=2, reps=2, intensity=60, ready model drops for 5 cycles → one write of 60, uv_en high 12 cycles, low 8, high 12, write of 0, done pulse, rep_count=2.
- reps=0, start → done within 3 cycles, zero I2C requests, uv_en never high.
- intensity=200, on=1, reps=1 → i2c_data=100 on first write, then 0.
- abort asserted mid second ON of reps=5 → uv_en low next edge, zero write issued, done pulse, rep_count=1.
- i2c_ready held high permanently → each write completes after I2C_ACK_TO cycles, run finishes normally.
- rst asserted during ON → next cycle all outputs 0, state IDLE; a new start runs a full sequence.

Source files
------------

// File: rtl/exposure_sequencer.sv
// exposure_sequencer: runs one UV exposure (intensity write, timed ON/OFF pulses, zero write) per start.
// Build option: define SOFT_START_EN to add a half-intensity soft-start hold before the first ON phase.
module exposure_sequencer #(
    parameter int unsigned TICK_DIV   = 16000,
    parameter int unsigned TIME_W     = 16,
    parameter int unsigned REP_W      = 8,
    parameter int unsigned INT_MAX    = 100,
    parameter int unsigned I2C_ACK_TO = 8,
    parameter int unsigned SOFT_MS    = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [TIME_W-1:0] on_time,
    input  logic [TIME_W-1:0] off_time,
    input  logic [REP_W-1:0]  repetitions,
    input  logic [7:0]        intensity,
    input  logic              i2c_ready,
    output logic              i2c_enable,
    output logic [7:0]        i2c_data,
    output logic              uv_en,
    output logic              busy,
    output logic              done,
    output logic [REP_W-1:0]  rep_count
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned ACK_W = (I2C_ACK_TO > 1) ? $clog2(I2C_ACK_TO) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(I2C_ACK_TO - 1);
    localparam logic [7:0]        INT_CLAMP = 8'(INT_MAX);
    localparam logic [TIME_W-1:0] SOFT_T    = TIME_W'(SOFT_MS);

`ifdef SOFT_START_EN
    typedef enum logic [3:0] {IDLE, WR_INT, WAIT_WR, SOFT, ON, OFF, WR_ZERO, WAIT_ZERO, DONE} state_t;
`else
    typedef enum logic [3:0] {IDLE, WR_INT, WAIT_WR, ON, OFF, WR_ZERO, WAIT_ZERO, DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [TIME_W-1:0] on_q, on_d, off_q, off_d, ms_q, ms_d;
    logic [REP_W-1:0]  reps_q, reps_d, rep_count_d;
    logic [7:0]        lvl_q, lvl_d, i2c_data_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [ACK_W-1:0]  wcnt_q, wcnt_d;
    logic              seen_low_q, seen_low_d, abort_pend_q, abort_pend_d;
    logic              i2c_enable_d, uv_en_d, busy_d, done_d;
`ifdef SOFT_START_EN
    logic              soft_pend_q, soft_pend_d;
`endif

    logic [TIME_W-1:0] phase_ms, ms_adv;
    logic [PRE_W-1:0]  pre_adv;
    logic              phase_end, wr_done;
    logic [REP_W-1:0]  rep_inc;
    logic [7:0]        lvl_in;

    // Length of the current timed phase in ms
    always_comb begin
        case (state_q)
            ON:      phase_ms = on_q;
            OFF:     phase_ms = off_q;
            default: phase_ms = SOFT_T;
        endcase
    end

    assign pre_adv   = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
    assign ms_adv    = (pre_q == PRE_LAST) ? ms_q + TIME_W'(1) : ms_q;
    assign phase_end = (phase_ms == '0) || ((pre_q == PRE_LAST) && (ms_q == phase_ms - TIME_W'(1)));
    assign wr_done   = i2c_ready && (seen_low_q || (wcnt_q == ACK_LAST));
    assign rep_inc   = (rep_count == '1) ? rep_count : rep_count + REP_W'(1);
    assign lvl_in    = ((intensity > INT_CLAMP) ? INT_CLAMP : intensity) & 8'h7F;

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        on_d         = on_q;
        off_d        = off_q;
        reps_d       = reps_q;
        lvl_d        = lvl_q;
        rep_count_d  = rep_count;
        i2c_enable_d = 1'b0;
        i2c_data_d   = i2c_data;
        pre_d        = '0;
        ms_d         = '0;
        wcnt_d       = '0;
        seen_low_d   = 1'b0;
        abort_pend_d = abort_pend_q;
`ifdef SOFT_START_EN
        soft_pend_d  = soft_pend_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    on_d         = on_time;
                    off_d        = off_time;
                    reps_d       = repetitions;
                    lvl_d        = lvl_in;
                    rep_count_d  = '0;
                    abort_pend_d = 1'b0;
`ifdef SOFT_START_EN
                    soft_pend_d  = 1'b1;
`endif
                    state_d      = (repetitions == '0) ? DONE : WR_INT;
                end
            end
            WR_INT: begin
                if (abort) begin
                    state_d = WR_ZERO;
                end else if (i2c_ready) begin
                    i2c_enable_d = 1'b1;
`ifdef SOFT_START_EN
                    i2c_data_d   = soft_pend_q ? (lvl_q >> 1) : lvl_q;
`else
                    i2c_data_d   = lvl_q;
`endif
                    state_d      = WAIT_WR;
                end
            end
            WAIT_WR: begin
                if (abort) abort_pend_d = 1'b1;
                if (wr_done) begin
                    if (abort || abort_pend_q) state_d = WR_ZERO;
`ifdef SOFT_START_EN
                    else if (soft_pend_q) state_d = SOFT;
`endif
                    else state_d = ON;
                end else begin
                    wcnt_d     = wcnt_q + ACK_W'(1);
                    seen_low_d = seen_low_q | ~i2c_ready;
                end
            end
`ifdef SOFT_START_EN
            SOFT: begin
                if (abort) begin
                    state_d = WR_ZERO;
                end else if (phase_end) begin
                    soft_pend_d = 1'b0;
                    state_d     = WR_INT;
                end else begin
                    pre_d = pre_adv;
                    ms_d  = ms_adv;
                end
            end
`endif
            ON: begin
                if (abort) begin
                    state_d = WR_ZERO;
                end else if (phase_end) begin
                    rep_count_d = rep_inc;
                    if (rep_inc == reps_q) state_d = WR_ZERO;
                    else if (off_q == '0)  state_d = ON;
                    else                   state_d = OFF;
                end else begin
                    pre_d = pre_adv;
                    ms_d  = ms_adv;
                end
            end
            OFF: begin
                if (abort) begin
                    state_d = WR_ZERO;
                end else if (phase_end) begin
                    state_d = ON;
                end else begin
                    pre_d = pre_adv;
                    ms_d  = ms_adv;
                end
            end
            WR_ZERO: begin
                if (i2c_ready) begin
                    i2c_enable_d = 1'b1;
                    i2c_data_d   = '0;
                    state_d      = WAIT_ZERO;
                end
            end
            WAIT_ZERO: begin
                if (wr_done) begin
                    state_d = DONE;
                end else begin
                    wcnt_d     = wcnt_q + ACK_W'(1);
                    seen_low_d = seen_low_q | ~i2c_ready;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
`ifdef SOFT_START_EN
        uv_en_d = ((state_d == ON) && (on_q != '0)) || (state_d == SOFT) ||
                  (((state_d == WR_INT) || (state_d == WAIT_WR)) && !soft_pend_d && !abort_pend_d);
`else
        uv_en_d = (state_d == ON) && (on_q != '0);
`endif
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            on_q         <= '0;
            off_q        <= '0;
            reps_q       <= '0;
            lvl_q        <= '0;
            pre_q        <= '0;
            ms_q         <= '0;
            wcnt_q       <= '0;
            seen_low_q   <= 1'b0;
            abort_pend_q <= 1'b0;
            i2c_enable   <= 1'b0;
            i2c_data     <= '0;
            uv_en        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rep_count    <= '0;
`ifdef SOFT_START_EN
            soft_pend_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            on_q         <= on_d;
            off_q        <= off_d;
            reps_q       <= reps_d;
            lvl_q        <= lvl_d;
            pre_q        <= pre_d;
            ms_q         <= ms_d;
            wcnt_q       <= wcnt_d;
            seen_low_q   <= seen_low_d;
            abort_pend_q <= abort_pend_d;
            i2c_enable   <= i2c_enable_d;
            i2c_data     <= i2c_data_d;
            uv_en        <= uv_en_d;
            busy         <= busy_d;
            done         <= done_d;
            rep_count    <= rep_count_d;
`ifdef SOFT_START_EN
            soft_pend_q  <= soft_pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_exposure_sequencer.sv
// tb_exposure_sequencer: randomized runs checked against a phase-level exposure model.
module tb_exposure_sequencer;

    localparam int unsigned TD     = 4;
    localparam int unsigned TIME_W = 16;
    localparam int unsigned REP_W  = 8;
    localparam int unsigned ACK_TO = 8;
    localparam int          LO_LEN = 5;

    logic              clk = 1'b0;
    logic              rst, start, abort;
    logic [TIME_W-1:0] on_time, off_time;
    logic [REP_W-1:0]  repetitions;
    logic [7:0]        intensity;
    logic              i2c_ready;
    logic              i2c_enable, uv_en, busy, done;
    logic [7:0]        i2c_data;
    logic [REP_W-1:0]  rep_count;

    exposure_sequencer #(
        .TICK_DIV(TD), .TIME_W(TIME_W), .REP_W(REP_W),
        .INT_MAX(100), .I2C_ACK_TO(ACK_TO), .SOFT_MS(50)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .on_time(on_time), .off_time(off_time), .repetitions(repetitions),
        .intensity(intensity), .i2c_ready(i2c_ready), .i2c_enable(i2c_enable),
        .i2c_data(i2c_data), .uv_en(uv_en), .busy(busy), .done(done),
        .rep_count(rep_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // I2C controller stand-in: ready drops for LO_LEN cycles per request, or stays high (mode 1)
    int ready_mode = 0;
    int lo_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            i2c_ready = 1'b1;
            lo_cnt    = 0;
        end else if (lo_cnt > 0) begin
            lo_cnt--;
            if (lo_cnt == 0) i2c_ready = 1'b1;
        end else if (i2c_enable && ready_mode == 0) begin
            i2c_ready = 1'b0;
            lo_cnt    = LO_LEN;
        end
    end

    // Observed run: writes, uv_en high/low run lengths, done pulses
    int         cyc = 0;
    logic [7:0] wr_q[$];
    int         hi_q[$];
    int         lo_q[$];
    int         cur_hi = 0, cur_lo = 0, done_cnt = 0, proto_err = 0, en_run = 0, en_bad = 0, uv_out = 0;
    int         start_cyc = 0, done_cyc = 0, first_en_cyc = -1, first_rise_cyc = -1;
    bit         had_hi = 0, prev_done = 0;
    always @(negedge clk) begin
        cyc++;
        if (start && !busy && !rst) begin
            wr_q.delete(); hi_q.delete(); lo_q.delete();
            cur_hi = 0; cur_lo = 0; had_hi = 0; done_cnt = 0; proto_err = 0;
            en_bad = 0; uv_out = 0; start_cyc = cyc; first_en_cyc = -1; first_rise_cyc = -1;
        end
        if (i2c_enable) begin
            wr_q.push_back(i2c_data);
            en_run++;
            if (en_run > 1) en_bad++;
            if (first_en_cyc < 0) first_en_cyc = cyc;
        end else begin
            en_run = 0;
        end
        if (uv_en) begin
            if (!busy) uv_out++;
            if (had_hi && cur_lo > 0) lo_q.push_back(cur_lo);
            cur_lo = 0;
            if (cur_hi == 0 && first_rise_cyc < 0) first_rise_cyc = cyc;
            cur_hi++;
            had_hi = 1;
        end else begin
            if (cur_hi > 0) begin
                hi_q.push_back(cur_hi);
                cur_hi = 0;
            end
            if (had_hi) cur_lo++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (!busy) proto_err++;
        end
        if (prev_done && busy) proto_err++;
        prev_done = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int on, input int off, input int reps, input int inten);
        on_time     = TIME_W'(on);
        off_time    = TIME_W'(off);
        repetitions = REP_W'(reps);
        intensity   = 8'(inten);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
    endtask

    // Full run compared against the phase-level model
    task automatic run_check(input string nm, input int on, input int off, input int reps,
                             input int inten, input int mode, input bit poke);
        int exp_hi[$];
        int exp_lo[$];
        int exp_int;
        ready_mode = mode;
        launch(on, off, reps, inten);
        if (poke) begin
            repeat (10) tick();
            if (busy) begin
                on_time = TIME_W'($urandom_range(1, 9)); off_time = TIME_W'($urandom_range(1, 9));
                repetitions = REP_W'($urandom_range(1, 9)); intensity = 8'($urandom_range(0, 255));
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        wait_done(4000);

        exp_int = (inten > 100) ? 100 : inten;
        if (on > 0 && reps > 0) begin
            if (off == 0) exp_hi.push_back(reps * on * int'(TD));
            else begin
                for (int i = 0; i < reps; i++) exp_hi.push_back(on * int'(TD));
                for (int i = 0; i < reps - 1; i++) exp_lo.push_back(off * int'(TD));
            end
        end

        check_eq({nm, ".done"}, done_cnt, 1);
        check_eq({nm, ".proto"}, proto_err, 0);
        check_eq({nm, ".en_width"}, en_bad, 0);
        check_eq({nm, ".uv_idle"}, uv_out, 0);
        check_eq({nm, ".nwr"}, wr_q.size(), (reps > 0) ? 2 : 0);
        if (wr_q.size() == 2 && reps > 0) begin
            check_eq({nm, ".wr_int"}, wr_q[0], exp_int);
            check_eq({nm, ".wr_zero"}, wr_q[1], 0);
        end
        check_eq({nm, ".nhi"}, hi_q.size(), exp_hi.size());
        for (int i = 0; i < exp_hi.size() && i < hi_q.size(); i++)
            check_eq($sformatf("%s.hi%0d", nm, i), hi_q[i], exp_hi[i]);
        check_eq({nm, ".nlo"}, lo_q.size(), exp_lo.size());
        for (int i = 0; i < exp_lo.size() && i < lo_q.size(); i++)
            check_eq($sformatf("%s.lo%0d", nm, i), lo_q[i], exp_lo[i]);
        check_eq({nm, ".reps"}, rep_count, reps);
        if (reps > 0 && on > 0)
            check_eq({nm, ".wr_lat"}, first_rise_cyc - first_en_cyc, (mode == 1) ? ACK_TO : LO_LEN + 1);
        if (reps == 0)
            check_eq({nm, ".quick"}, (done_cyc - start_cyc) <= 3, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int b;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        on_time = '0; off_time = '0; repetitions = '0; intensity = '0;
        i2c_ready = 1'b1;
        repeat (3) tick();
        check_eq("rst.i2c_enable", i2c_enable, 0);
        check_eq("rst.i2c_data", i2c_data, 0);
        check_eq("rst.uv_en", uv_en, 0);
        check_eq("rst.busy", busy, 0);
        check_eq("rst.done", done, 0);
        check_eq("rst.rep_count", rep_count, 0);
        rst = 1'b0;
        tick();

        run_check("base", 3, 2, 2, 60, 0, 0);
        run_check("zero_reps", 3, 2, 0, 60, 0, 0);
        run_check("clamp", 1, 0, 1, 200, 0, 0);
        run_check("stuck", 2, 1, 2, 50, 1, 0);
        run_check("on0", 0, 2, 3, 30, 0, 0);
        run_check("off0", 2, 0, 3, 100, 0, 1);

        // abort in the second ON phase
        ready_mode = 0;
        launch(3, 2, 5, 60);
        n = 0;
        while (!(hi_q.size() == 1 && cur_hi >= 2) && n < 500) begin tick(); n++; end
        check_eq("ab_on.reach", (hi_q.size() == 1 && cur_hi >= 2), 1);
        abort = 1'b1;
        tick();
        check_eq("ab_on.uv_next", uv_en, 0);
        wait_done(2000);
        abort = 1'b0;
        tick();
        check_eq("ab_on.done", done_cnt, 1);
        check_eq("ab_on.nwr", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            check_eq("ab_on.wr_int", wr_q[0], 60);
            check_eq("ab_on.wr_zero", wr_q[1], 0);
        end
        check_eq("ab_on.first_hi", (hi_q.size() > 0) ? hi_q[0] : -1, 3 * TD);
        check_eq("ab_on.reps", rep_count, 1);

        // short abort during the intensity write
        launch(2, 1, 3, 90);
        n = 0;
        while (!i2c_enable && n < 50) begin tick(); n++; end
        check_eq("ab_wr.reach", i2c_enable, 1);
        abort = 1'b1;
        repeat (2) tick();
        abort = 1'b0;
        wait_done(2000);
        check_eq("ab_wr.done", done_cnt, 1);
        check_eq("ab_wr.nwr", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            check_eq("ab_wr.wr_int", wr_q[0], 90);
            check_eq("ab_wr.wr_zero", wr_q[1], 0);
        end
        check_eq("ab_wr.uv_never", hi_q.size() + cur_hi, 0);
        check_eq("ab_wr.reps", rep_count, 0);

        // simultaneous start and abort in IDLE
        on_time = 16'd2; off_time = 16'd1; repetitions = 8'd2; intensity = 8'd40;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        b = 0;
        repeat (4) begin
            if (busy || i2c_enable) b++;
            tick();
        end
        check_eq("start_abort.ignored", b, 0);

        // reset during ON, then a full run
        launch(5, 1, 3, 40);
        n = 0;
        while (!uv_en && n < 100) begin tick(); n++; end
        check_eq("rst_on.reach", uv_en, 1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_eq("rst_on.uv_en", uv_en, 0);
        check_eq("rst_on.busy", busy, 0);
        check_eq("rst_on.done", done, 0);
        check_eq("rst_on.i2c_enable", i2c_enable, 0);
        check_eq("rst_on.i2c_data", i2c_data, 0);
        check_eq("rst_on.rep_count", rep_count, 0);
        rst = 1'b0;
        tick();
        run_check("post_rst", 2, 1, 2, 70, 0, 0);

        for (int k = 0; k < 12; k++) begin
            run_check($sformatf("rnd%0d", k),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
